// File: rtl/booth_mult_seq_pkg.sv
//------------------------------------------------------------------------------
// Module   : booth_pkg
// Brief    : Shared types and helpers for the sequential Booth multiplier.
//            The FINISH state is only reachable when BOOTH_EARLY_TERM_EN is set.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package booth_pkg;

   // Widest operand the extension helper can produce
   localparam int EXT_MAX = 64;

   // One-hot controller states
   typedef enum logic [6:0] {
      IDLE   = 7'b000_0001,
      EVAL   = 7'b000_0010,
      ADD    = 7'b000_0100,
      SUB    = 7'b000_1000,
      SHIFT  = 7'b001_0000,
      FINISH = 7'b010_0000,
      DONE   = 7'b100_0000
   } state_t;

   // Extend a width-bit operand: sign-extend when signed_flag=1, else zero-extend
   function automatic logic [EXT_MAX-1:0] ext_operand(input logic [EXT_MAX-1:0] value,
                                                      input logic               signed_flag,
                                                      input int                 width);
      logic [EXT_MAX-1:0] res;
      logic               fill;
      fill = signed_flag & value[width-1];
      for (int i = 0; i < EXT_MAX; i++) begin
         res[i] = (i < width) ? value[i] : fill;
      end
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/booth_mult_seq_if.sv
//------------------------------------------------------------------------------
// Module   : booth_mult_seq_if
// Brief    : Operand/product handshake bundle for booth_mult_seq.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface booth_mult_seq_if #(
   parameter int WIDTH = 8
) ();

   logic               in_valid;
   logic               in_ready;
   logic               mode_signed;
   logic [WIDTH-1:0]   multiplicand;
   logic [WIDTH-1:0]   multiplier;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] product;
   logic               busy;

   // Operand source / product consumer side
   modport master (
      output in_valid, mode_signed, multiplicand, multiplier, out_ready,
      input  in_ready, out_valid, product, busy
   );

   // Multiplier side
   modport slave (
      input  in_valid, mode_signed, multiplicand, multiplier, out_ready,
      output in_ready, out_valid, product, busy
   );

endinterface

`default_nettype wire

// File: rtl/booth_mult_seq_addsub.sv
//------------------------------------------------------------------------------
// Module   : booth_addsub
// Brief    : W-bit adder/subtractor, carry/borrow discarded.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module booth_addsub #(
   parameter int W = 9
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic [W-1:0] sum
);

   // Single shared arithmetic unit for both Booth add and subtract steps
   always_comb begin
      sum = sub ? (a - b) : (a + b);
   end

endmodule

`default_nettype wire

// File: rtl/booth_mult_seq.sv
//------------------------------------------------------------------------------
// Module   : booth_mult_seq
// Brief    : Sequential radix-2 Booth multiplier, signed/unsigned per
//            transaction, valid/ready on operands and product.
//            Optional macro BOOTH_EARLY_TERM_EN skips trailing no-op
//            iterations with a single barrel shift.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module booth_mult_seq
   import booth_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 2)
) (
   input  logic              clk,
   input  logic              rst,
   booth_mult_seq_if.slave   bus
);

   // One extra bit lets unsigned maxima and the signed minimum be exact
   localparam int E = WIDTH + 1;

   state_t             state;
   logic [E-1:0]       a;
   logic [E-1:0]       q;
   logic [E-1:0]       m;
   logic               q_m1;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] product_reg;
   logic               out_valid_reg;
   logic               busy_reg;

   logic [E-1:0]       m_ext;
   logic [E-1:0]       r_ext;
   logic [E-1:0]       sum;
   logic [2*E-1:0]     shift_val;

`ifdef BOOTH_EARLY_TERM_EN
   logic [E-1:0]          r_rem;
   logic signed [2*E-1:0] fin_val;
`endif

   assign m_ext = E'(ext_operand(EXT_MAX'(bus.multiplicand), bus.mode_signed, WIDTH));
   assign r_ext = E'(ext_operand(EXT_MAX'(bus.multiplier),   bus.mode_signed, WIDTH));

   // {A,Q} after one arithmetic right shift; Q[0] moves into Q_-1 separately
   assign shift_val = {a[E-1], a, q[E-1:1]};

`ifdef BOOTH_EARLY_TERM_EN
   // Collapse all remaining no-op iterations into one shift
   assign fin_val = $signed({a, q}) >>> cnt;
`endif

   booth_addsub #(.W(E)) u_addsub (
      .a   (a),
      .b   (m),
      .sub (state == SUB),
      .sum (sum)
   );

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = out_valid_reg;
   assign bus.product   = product_reg;
   assign bus.busy      = busy_reg;

   // Controller and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         a             <= '0;
         q             <= '0;
         m             <= '0;
         q_m1          <= 1'b0;
         cnt           <= '0;
         product_reg   <= '0;
         out_valid_reg <= 1'b0;
         busy_reg      <= 1'b0;
`ifdef BOOTH_EARLY_TERM_EN
         r_rem         <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  m        <= m_ext;
                  q        <= r_ext;
                  a        <= '0;
                  q_m1     <= 1'b0;
                  cnt      <= CNT_W'(E);
                  busy_reg <= 1'b1;
`ifdef BOOTH_EARLY_TERM_EN
                  r_rem    <= r_ext;
`endif
                  state    <= EVAL;
               end
            end
            EVAL: begin
`ifdef BOOTH_EARLY_TERM_EN
               if (r_rem == {E{q_m1}}) state <= FINISH;
               else
`endif
               begin
                  case ({q[0], q_m1})
                     2'b01:   state <= ADD;
                     2'b10:   state <= SUB;
                     default: state <= SHIFT;
                  endcase
               end
            end
            ADD, SUB: begin
               a     <= sum;
               state <= SHIFT;
            end
            SHIFT: begin
               a    <= shift_val[2*E-1:E];
               q    <= shift_val[E-1:0];
               q_m1 <= q[0];
               cnt  <= cnt - CNT_W'(1);
`ifdef BOOTH_EARLY_TERM_EN
               r_rem <= {r_rem[E-1], r_rem[E-1:1]};
`endif
               if (cnt == CNT_W'(1)) begin
                  product_reg   <= shift_val[2*WIDTH-1:0];
                  out_valid_reg <= 1'b1;
                  state         <= DONE;
               end else begin
                  state <= EVAL;
               end
            end
            FINISH: begin
`ifdef BOOTH_EARLY_TERM_EN
               a             <= fin_val[2*E-1:E];
               q             <= fin_val[E-1:0];
               cnt           <= '0;
               product_reg   <= fin_val[2*WIDTH-1:0];
               out_valid_reg <= 1'b1;
               state         <= DONE;
`else
               state <= IDLE;
`endif
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_reg <= 1'b0;
                  busy_reg      <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: begin
               out_valid_reg <= 1'b0;
               busy_reg      <= 1'b0;
               state         <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_booth_mult_seq.sv
//------------------------------------------------------------------------------
// Module   : tb_booth_mult_seq
// Brief    : Directed self-checking bench for booth_mult_seq (WIDTH=8).
//            Latency expectations follow BOOTH_EARLY_TERM_EN when defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_booth_mult_seq;

   localparam int WIDTH = 8;
`ifdef BOOTH_EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   booth_mult_seq_if #(.WIDTH(WIDTH)) bus ();

   booth_mult_seq #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Wait for out_valid, counting clock edges after the accept edge
   task automatic wait_valid(input int bound, output int lat);
      lat = 0;
      while (!bus.out_valid && lat < bound) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // One full transaction; exp_lat < 0 means only the max_lat bound is checked
   task automatic run_mult(input string tag, input logic ms, input logic [7:0] md,
                           input logic [7:0] mr, input logic [15:0] exp_p,
                           input int exp_lat, input int max_lat);
      int lat;
      @(negedge clk);
      check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      bus.in_valid     = 1'b1;
      bus.mode_signed  = ms;
      bus.multiplicand = md;
      bus.multiplier   = mr;
      @(negedge clk);
      bus.in_valid = 1'b0;
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      wait_valid(max_lat + 5, lat);
      check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
      if (exp_lat >= 0) check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      else              check({tag, "_latency_bound"}, 32'(lat <= max_lat), 32'd1);
      check({tag, "_product"}, 32'(bus.product), 32'(exp_p));
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
      check({tag, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      int lat;
      bus.in_valid     = 1'b0;
      bus.mode_signed  = 1'b0;
      bus.multiplicand = '0;
      bus.multiplier   = '0;
      bus.out_ready    = 1'b0;
      rst              = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_in_ready",  32'(bus.in_ready),  32'd1);
      check("rst_busy",      32'(bus.busy),      32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_product",   32'(bus.product),   32'd0);
      rst = 1'b0;

      // Directed vectors: tag, signed, M, R, product, exact latency, bound
      run_mult("s_m3x5",     1'b1, 8'hFD, 8'h05, 16'hFFF1, EARLY ? -1 : 22, 27);
      run_mult("u_255x255",  1'b0, 8'hFF, 8'hFF, 16'hFE01, EARLY ? -1 : 20, 27);
      run_mult("s_m128xm128",1'b1, 8'h80, 8'h80, 16'h4000, EARLY ? -1 : 19, 27);
      run_mult("s_0x0",      1'b1, 8'h00, 8'h00, 16'h0000, EARLY ? -1 : 18, EARLY ? 3 : 18);
      run_mult("s_127xm1",   1'b1, 8'h7F, 8'hFF, 16'hFF81, -1, 27);
      run_mult("u_200x3",    1'b0, 8'hC8, 8'h03, 16'h0258, -1, 27);
      run_mult("s_m128x127", 1'b1, 8'h80, 8'h7F, 16'hC080, -1, 27);

      // Backpressure: hold DONE, offer operands while busy
      @(negedge clk);
      bus.in_valid     = 1'b1;
      bus.mode_signed  = 1'b0;
      bus.multiplicand = 8'd12;
      bus.multiplier   = 8'd10;
      @(negedge clk);
      bus.multiplicand = 8'd9;
      bus.multiplier   = 8'd9;
      wait_valid(32, lat);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_hold_product", 32'(bus.product),   32'h0078);
         check("bp_hold_valid",   32'(bus.out_valid), 32'd1);
         check("bp_hold_ready",   32'(bus.in_ready),  32'd0);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("bp_release_ready", 32'(bus.in_ready),  32'd1);
      check("bp_release_valid", 32'(bus.out_valid), 32'd0);
      check("bp_release_busy",  32'(bus.busy),      32'd0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("bp_next_busy",  32'(bus.busy),     32'd1);
      check("bp_next_ready", 32'(bus.in_ready), 32'd0);
      wait_valid(32, lat);
      check("bp_next_valid",   32'(bus.out_valid), 32'd1);
      check("bp_next_product", 32'(bus.product),   32'h0051);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;

      // Reset in the middle of an iteration
      bus.in_valid     = 1'b1;
      bus.mode_signed  = 1'b1;
      bus.multiplicand = 8'd100;
      bus.multiplier   = 8'd3;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_busy",      32'(bus.busy),      32'd0);
      check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("mid_rst_product",   32'(bus.product),   32'd0);
      check("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
      run_mult("s_7x6", 1'b1, 8'd7, 8'd6, 16'h002A, EARLY ? -1 : 20, 27);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
